// File: rtl/dffnsnq_preset_seq.sv
// Staggered SETN preset sequencer for a bank of negative-edge set-flop groups.
// Gates the bank clock enable around each preset and pulses DONE when the mask is exhausted.
module dffnsnq_preset_seq #(
   parameter int NGRP    = 4,
   parameter int GATE_W  = 1,
   parameter int PULSE_W = 2,
   parameter int REC_W   = 2,
   parameter int CNT_W   = 4
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            REQ,
   input  logic [NGRP-1:0] MASK,
   output logic            BUSY,
   output logic            DONE,
   output logic [NGRP-1:0] SETN,
   output logic            CLK_EN,
   output logic [3:0]      CUR_GRP
);

   localparam int GATE_E  = (GATE_W  < 1) ? 1 : GATE_W;
   localparam int PULSE_E = (PULSE_W < 1) ? 1 : PULSE_W;
   localparam int REC_E   = (REC_W   < 1) ? 1 : REC_W;

   localparam logic [CNT_W-1:0] GATE_LD  = CNT_W'(GATE_E - 1);
   localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_E - 1);
   localparam logic [CNT_W-1:0] REC_LD   = CNT_W'(REC_E - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_GATE  = 3'd1;
   localparam logic [2:0] S_SET   = 3'd2;
   localparam logic [2:0] S_RECOV = 3'd3;
   localparam logic [2:0] S_FIN   = 3'd4;

   logic [2:0]      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [NGRP-1:0] mask_q, mask_d;
   logic [3:0]      grp_q, grp_d;
   logic [NGRP-1:0] setn_q, setn_d;
   logic            clk_en_q, clk_en_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [3:0]      cur_grp_q, cur_grp_d;
   logic [3:0]      low_grp;

   function automatic logic [3:0] lowest(input logic [NGRP-1:0] m);
      logic [3:0] r;
      r = '0;
      for (int i = NGRP - 1; i >= 0; i--) begin
         if (m[i]) r = 4'(i);
      end
      return r;
   endfunction

   always_comb begin
      low_grp = lowest(mask_q);
   end

   // Next-state logic; entering SET removes the chosen group from the pending mask.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mask_d  = mask_q;
      grp_d   = grp_q;
      case (state_q)
         S_IDLE: begin
            if (REQ) begin
               if (MASK != '0) begin
                  mask_d  = MASK;
                  cnt_d   = GATE_LD;
                  state_d = S_GATE;
               end else begin
                  state_d = S_FIN;
               end
            end
         end
         S_GATE, S_RECOV: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else if (mask_q != '0) begin
               grp_d   = low_grp;
               cnt_d   = PULSE_LD;
               state_d = S_SET;
               for (int i = 0; i < NGRP; i++) begin
                  if (4'(i) == low_grp) mask_d[i] = 1'b0;
               end
            end else begin
               state_d = S_FIN;
            end
         end
         S_SET: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               cnt_d   = REC_LD;
               state_d = S_RECOV;
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state so they can be registered with no input-to-output path.
   always_comb begin
      clk_en_d  = (state_d == S_IDLE) || (state_d == S_FIN);
      busy_d    = (state_d != S_IDLE);
      done_d    = (state_d == S_FIN);
      cur_grp_d = ((state_d == S_SET) || (state_d == S_RECOV)) ? grp_d : 4'd0;
      setn_d    = '1;
      for (int i = 0; i < NGRP; i++) begin
         if ((state_d == S_SET) && (grp_d == 4'(i))) setn_d[i] = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         mask_q    <= '0;
         grp_q     <= '0;
         setn_q    <= '1;
         clk_en_q  <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         cur_grp_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mask_q    <= mask_d;
         grp_q     <= grp_d;
         setn_q    <= setn_d;
         clk_en_q  <= clk_en_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         cur_grp_q <= cur_grp_d;
      end
   end

   assign SETN    = setn_q;
   assign CLK_EN  = clk_en_q;
   assign BUSY    = busy_q;
   assign DONE    = done_q;
   assign CUR_GRP = cur_grp_q;

endmodule

// File: tb/tb_dffnsnq_preset_seq.sv
// Bench for dffnsnq_preset_seq: a cycle table for one request, directed corner sequences,
// and random requests checked against a schedule computed from the group mask.
module tb_dffnsnq_preset_seq;

   localparam int NGRP    = 4;
   localparam int GATE_W  = 1;
   localparam int PULSE_W = 2;
   localparam int REC_W   = 2;
   localparam int CNT_W   = 4;
   localparam int PE      = (PULSE_W < 1) ? 1 : PULSE_W;
   localparam int RE      = (REC_W < 1) ? 1 : REC_W;

   logic       CLK;
   logic       RST;
   logic       REQ;
   logic [3:0] MASK;
   logic       BUSY;
   logic       DONE;
   logic [3:0] SETN;
   logic       CLK_EN;
   logic [3:0] CUR_GRP;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [3:0] setn;
      logic       clkEn;
      logic       busy;
      logic       done;
      logic [3:0] curGrp;
   } obs_t;

   typedef struct {
      logic       req;
      logic [3:0] mask;
      obs_t       exp;
   } vec_t;

   vec_t vecs[11];

   dffnsnq_preset_seq #(
      .NGRP(NGRP), .GATE_W(GATE_W), .PULSE_W(PULSE_W), .REC_W(REC_W), .CNT_W(CNT_W)
   ) dut (
      .CLK(CLK), .RST(RST), .REQ(REQ), .MASK(MASK), .BUSY(BUSY), .DONE(DONE),
      .SETN(SETN), .CLK_EN(CLK_EN), .CUR_GRP(CUR_GRP)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic applyStimulus(input logic req, input logic [3:0] mask);
      REQ  = req;
      MASK = mask;
   endtask

   task automatic checkOutput(input string name, input int cyc, input obs_t exp);
      obs_t act;
      act = {SETN, CLK_EN, BUSY, DONE, CUR_GRP};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s cycle %0d: got setn=%b clk_en=%b busy=%b done=%b cur=%0d, expected setn=%b clk_en=%b busy=%b done=%b cur=%0d",
                  name, cyc, act.setn, act.clkEn, act.busy, act.done, act.curGrp,
                  exp.setn, exp.clkEn, exp.busy, exp.done, exp.curGrp);
      end
   endtask

   task automatic checkInvariants(input string name, input int cyc);
      checks++;
      if ($countones(~SETN) > 1 || (SETN != 4'hF && CLK_EN !== 1'b0)) begin
         errors++;
         $display("[TB] FAIL %s invariant cycle %0d: got setn=%b clk_en=%b, expected at most one low bit and clk_en=0 while low",
                  name, cyc, SETN, CLK_EN);
      end
   endtask

   function automatic int latency(input logic [3:0] m);
      if (m == 4'h0) return 1;
      return GATE_W + $countones(m) * (PE + RE) + 1;
   endfunction

   function automatic int nthBit(input logic [3:0] m, input int n);
      int seen;
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         if (m[i]) begin
            if (seen == n) return i;
            seen++;
         end
      end
      return 0;
   endfunction

   // Expected outputs at cycle t after the accept edge, from the slot schedule.
   function automatic obs_t expOut(input logic [3:0] m, input int t);
      obs_t o;
      int total, u, slot, ph, grp;
      o = '{setn: 4'hF, clkEn: 1'b1, busy: 1'b0, done: 1'b0, curGrp: 4'd0};
      total = latency(m);
      if (t >= 1 && t <= total) begin
         o.busy = 1'b1;
         if (t == total) begin
            o.done = 1'b1;
         end else begin
            o.clkEn = 1'b0;
            u = t - 1 - GATE_W;
            if (u >= 0) begin
               slot = u / (PE + RE);
               ph   = u % (PE + RE);
               grp  = nthBit(m, slot);
               o.curGrp = 4'(grp);
               if (ph < PE) o.setn = o.setn & ~(4'b0001 << grp);
            end
         end
      end
      return o;
   endfunction

   task automatic runAndCheck(input logic [3:0] m, input int inj, input logic [3:0] injMask, input string name);
      int total;
      total = latency(m);
      applyStimulus(1'b1, m);
      tick();
      for (int t = 1; t <= total + 1; t++) begin
         checkOutput(name, t, expOut(m, t));
         checkInvariants(name, t);
         if (t == inj) applyStimulus(1'b1, injMask);
         else applyStimulus(1'b0, 4'($urandom_range(0, 15)));
         tick();
      end
   endtask

   initial begin
      obs_t idle;
      logic [3:0] m;
      int inj;
      idle = '{setn: 4'hF, clkEn: 1'b1, busy: 1'b0, done: 1'b0, curGrp: 4'd0};

      vecs[0]  = '{1'b1, 4'b0101, '{4'hF, 1'b0, 1'b1, 1'b0, 4'd0}};
      vecs[1]  = '{1'b0, 4'b0101, '{4'hE, 1'b0, 1'b1, 1'b0, 4'd0}};
      vecs[2]  = '{1'b0, 4'b0101, '{4'hE, 1'b0, 1'b1, 1'b0, 4'd0}};
      vecs[3]  = '{1'b0, 4'b0101, '{4'hF, 1'b0, 1'b1, 1'b0, 4'd0}};
      vecs[4]  = '{1'b0, 4'b0101, '{4'hF, 1'b0, 1'b1, 1'b0, 4'd0}};
      vecs[5]  = '{1'b0, 4'b0101, '{4'hB, 1'b0, 1'b1, 1'b0, 4'd2}};
      vecs[6]  = '{1'b0, 4'b0101, '{4'hB, 1'b0, 1'b1, 1'b0, 4'd2}};
      vecs[7]  = '{1'b0, 4'b0101, '{4'hF, 1'b0, 1'b1, 1'b0, 4'd2}};
      vecs[8]  = '{1'b0, 4'b0101, '{4'hF, 1'b0, 1'b1, 1'b0, 4'd2}};
      vecs[9]  = '{1'b0, 4'b0101, '{4'hF, 1'b1, 1'b1, 1'b1, 4'd0}};
      vecs[10] = '{1'b0, 4'b0101, '{4'hF, 1'b1, 1'b0, 1'b0, 4'd0}};

      RST = 1'b1;
      applyStimulus(1'b0, 4'h0);
      tick();
      tick();
      checkOutput("reset", 0, idle);
      RST = 1'b0;

      for (int i = 0; i < 11; i++) begin
         applyStimulus(vecs[i].req, vecs[i].mask);
         tick();
         checkOutput("table0101", i + 1, vecs[i].exp);
      end
      applyStimulus(1'b0, 4'h0);
      tick();

      runAndCheck(4'h0, -1, 4'h0, "mask0000");

      runAndCheck(4'hF, 3, 4'h1, "mask1111");
      for (int i = 0; i < 3; i++) begin
         checkOutput("dropped_req", i, idle);
         tick();
      end

      applyStimulus(1'b1, 4'b0010);
      tick();
      applyStimulus(1'b0, 4'b0010);
      tick();
      checkOutput("pre_reset", 2, expOut(4'b0010, 2));
      RST = 1'b1;
      tick();
      checkOutput("mid_reset", 3, idle);
      RST = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         checkOutput("post_reset", i, idle);
      end

      for (int r = 0; r < 200; r++) begin
         m   = 4'($urandom_range(0, 15));
         inj = ($urandom_range(0, 1) == 1) ? $urandom_range(1, latency(m)) : -1;
         runAndCheck(m, inj, 4'($urandom_range(0, 15)), "random");
         if ($urandom_range(0, 3) == 0) tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
